// File: rtl/dds_pkg.sv
// Shared definitions for the DDS audio path: I2S transmitter state encoding and synchroniser limits.
package dds_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_e;

  localparam int I2S_MIN_SYNC = 2;

  // Depth actually built: a request below the metastability floor is raised to it.
  function automatic int sync_depth(input int req);
    return (req < I2S_MIN_SYNC) ? I2S_MIN_SYNC : req;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous clock-like input, followed by a one-flop edge detector.
module sync_edge_det
  import dds_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_50,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int STAGES = sync_depth(SYNC_STAGES);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_50) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S serial transmitter toward the codec DAC, slaved to codec-driven bclk/lrclk.
// Build option: I2S_LEFT_JUSTIFIED_EN selects left-justified framing (no 1-bclk MSB delay).
module i2s_dac_tx
  import dds_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic              bclk,
  input  logic              lrclk,
  input  logic [DATA_W-1:0] sample_l,
  input  logic [DATA_W-1:0] sample_r,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              dacdat,
  output logic              frame_start,
  output logic              underrun
);

  // state | meaning
  // IDLE  | no frame seen since reset, dacdat held at 0
  // LEFT  | shifting the left word of the current pair
  // RIGHT | shifting the right word of the same pair
  i2s_state_e state_q;

  logic bclk_lvl, bclk_rise, bclk_fall;
  logic lr_lvl, lr_rise, lr_fall;
  logic unused_sync;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk_50   (clk_50),
    .rst      (rst),
    .async_in (bclk),
    .level    (bclk_lvl),
    .rise     (bclk_rise),
    .fall     (bclk_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_lr_sync (
    .clk_50   (clk_50),
    .rst      (rst),
    .async_in (lrclk),
    .level    (lr_lvl),
    .rise     (lr_rise),
    .fall     (lr_fall)
  );

  assign unused_sync = bclk_lvl ^ lr_rise ^ lr_fall;

  logic              lr_smp_q;
  logic              load_pend_q;
  logic [DATA_W-1:0] shift_q;
  logic              dacdat_q;
  logic [DATA_W-1:0] hold_l_q, hold_r_q;
  logic              hold_full_q;
  logic [DATA_W-1:0] pair_l_q, pair_r_q;
  logic              underrun_q;

  logic lr_chg, lr_new, slot_load, left_load, right_load, xfer;

`ifdef I2S_LEFT_JUSTIFIED_EN
  // Track the synchronised level directly so the load lands on the bclk_fall that carries the lrclk change.
  assign lr_chg = (lr_lvl != lr_smp_q);
`else
  assign lr_chg = bclk_rise & (lr_lvl != lr_smp_q);
`endif

  assign lr_new     = lr_chg ? lr_lvl : lr_smp_q;
  assign slot_load  = bclk_fall & (load_pend_q | lr_chg);
  assign left_load  = slot_load & ~lr_new;
  assign right_load = slot_load & lr_new & (state_q != IDLE);
  assign xfer       = sample_valid & ~hold_full_q;

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q     <= IDLE;
      lr_smp_q    <= 1'b0;
      load_pend_q <= 1'b0;
      shift_q     <= '0;
      dacdat_q    <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      pair_l_q    <= '0;
      pair_r_q    <= '0;
      underrun_q  <= 1'b0;
    end else begin
      lr_smp_q <= lr_new;
      if (lr_chg)    load_pend_q <= 1'b1;
      if (bclk_fall) load_pend_q <= 1'b0;

      if (left_load) begin
        state_q <= LEFT;
        if (hold_full_q) begin
          pair_l_q            <= hold_l_q;
          pair_r_q            <= hold_r_q;
          {dacdat_q, shift_q} <= {hold_l_q, 1'b0};
        end else begin
          // Empty holding register: replay the previous pair so L/R stay matched.
          underrun_q          <= 1'b1;
          {dacdat_q, shift_q} <= {pair_l_q, 1'b0};
        end
      end else if (right_load) begin
        state_q             <= RIGHT;
        {dacdat_q, shift_q} <= {pair_r_q, 1'b0};
      end else if (bclk_fall && (state_q != IDLE)) begin
        {dacdat_q, shift_q} <= {shift_q, 1'b0};
      end

      // A transfer only happens while empty, so it can never race the consume below.
      if (xfer) begin
        hold_l_q    <= sample_l;
        hold_r_q    <= sample_r;
        hold_full_q <= 1'b1;
      end else if (left_load && hold_full_q) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  assign sample_ready = ~hold_full_q;
  assign dacdat       = dacdat_q;
  assign frame_start  = left_load;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx: the bench plays the codec clock master and samples dacdat on bclk rises.
module tb_i2s_dac_tx;

  localparam int W    = 16;
  localparam int HALF = 8;
`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam int DLY = 0;
`else
  localparam int DLY = 1;
`endif

  logic         clk_50 = 1'b0;
  logic         rst = 1'b1;
  logic         bclk = 1'b0;
  logic         lrclk = 1'b1;
  logic [W-1:0] sample_l = '0;
  logic [W-1:0] sample_r = '0;
  logic         sample_valid = 1'b0;
  logic         sample_ready, dacdat, frame_start, underrun;

  i2s_dac_tx #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .clk_50       (clk_50),
    .rst          (rst),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .dacdat       (dacdat),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always #10 clk_50 = ~clk_50;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pairs accepted but not yet sent, last pair sent, sticky underrun.
  logic [W-1:0] q_l[$];
  logic [W-1:0] q_r[$];
  logic [W-1:0] cur_l = '0, cur_r = '0;
  logic         exp_underrun = 1'b0;
  int           fs_seen = 0;
  bit           prev_xfer = 0, prev_fs = 0;

  always @(negedge clk_50) begin
    if (rst) begin
      q_l.delete();
      q_r.delete();
      cur_l        = '0;
      cur_r        = '0;
      exp_underrun = 1'b0;
      prev_xfer    = 0;
      prev_fs      = 0;
    end else begin
      if (prev_xfer) check_eq("ready_after_xfer", sample_ready, 0);
      if (prev_fs) begin
        check_eq("ready_after_fs", sample_ready, 1);
        check_eq("fs_pulse_width", frame_start, 0);
      end
      if (frame_start) begin
        fs_seen++;
        if (q_l.size() > 0) begin
          cur_l = q_l.pop_front();
          cur_r = q_r.pop_front();
        end else begin
          exp_underrun = 1'b1;
        end
      end
      prev_fs   = frame_start;
      prev_xfer = sample_valid && sample_ready;
      if (prev_xfer) begin
        q_l.push_back(sample_l);
        q_r.push_back(sample_r);
      end
    end
  end

  // Codec-side view of the serial stream.
  bit           seen_hi = 0, act_valid = 0, rst_fired = 0;
  int           act_k = 0, exp_left_loads = 0;
  logic [W-1:0] act_word = '0;

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic bclk_cycle(input bit toggle, input bit load, input int rst_k);
    logic exp_bit;
    bit   rst_now;
    bclk = 1'b0;
    if (toggle) lrclk = ~lrclk;
    act_k++;
    if (load) act_k = 0;
    repeat (HALF) tick();
    if (load) begin
      if (!lrclk && seen_hi) begin
        act_valid = 1'b1;
        act_word  = cur_l;
        exp_left_loads++;
        check_eq("frame_count", fs_seen, exp_left_loads);
      end else if (lrclk && act_valid) begin
        act_word = cur_r;
      end
    end
    exp_bit = (act_valid && act_k < W) ? act_word[W-1-act_k] : 1'b0;
    check_eq("dacdat", dacdat, exp_bit);
    check_eq("underrun", underrun, exp_underrun);
    if (lrclk) seen_hi = 1'b1;
    rst_now = (rst_k >= 0) && !rst_fired && lrclk && act_valid && (act_k == rst_k);
    bclk = 1'b1;
    for (int t = 0; t < HALF; t++) begin
      tick();
      if (rst_now && t == 1) rst = 1'b1;
      if (rst_now && t == 2) begin
        check_eq("midrst_dacdat", dacdat, 0);
        check_eq("midrst_ready", sample_ready, 1);
        check_eq("midrst_underrun", underrun, 0);
        rst       = 1'b0;
        seen_hi   = 0;
        act_valid = 0;
        rst_fired = 1;
      end
    end
  endtask

  task automatic run_slots(input int n_slots, input int slot_len, input int rst_k);
    for (int s = 0; s < n_slots; s++)
      for (int b = 0; b < slot_len; b++)
        bclk_cycle(b == 0, b == DLY, rst_k);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    check_eq("reset_dacdat", dacdat, 0);
    check_eq("reset_ready", sample_ready, 1);
    check_eq("reset_frame_start", frame_start, 0);
    check_eq("reset_underrun", underrun, 0);
    rst       = 1'b0;
    seen_hi   = 0;
    act_valid = 0;
    act_k     = 0;
    repeat (4) bclk_cycle(1'b0, 1'b0, -1);
  endtask

  task automatic push_pair(input logic [W-1:0] l, input logic [W-1:0] r);
    int budget;
    budget       = 4000;
    sample_l     = l;
    sample_r     = r;
    sample_valid = 1'b1;
    while (budget > 0) begin
      @(negedge clk_50);
      if (sample_ready) break;
      budget--;
    end
    tick();
    sample_valid = 1'b0;
    if (budget == 0) check_eq("push_timeout", 1, 0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] base;
    int           waited;

    // Basic frame with the fixed pair.
    do_reset();
    fork
      run_slots(2, 32, -1);
      push_pair(16'hA5C3, 16'h0F0F);
    join

    // Single random pair, then starve the transmitter.
    do_reset();
    fork
      run_slots(6, 32, -1);
      begin
        repeat ($urandom_range(0, 30)) tick();
        push_pair(W'($urandom), W'($urandom));
      end
    join

    // Back-pressure with incrementing pairs.
    do_reset();
    base = W'($urandom);
    fork
      run_slots(10, 32, -1);
      for (int i = 0; i < 5; i++) push_pair(base + W'(i), ~(base + W'(i)));
    join
    check_eq("backlog_empty", q_l.size(), 0);

    // Short slots truncate the LSBs.
    do_reset();
    fork
      run_slots(4, 12, -1);
      push_pair(16'hFFF0, W'($urandom));
    join

    // Reset at bit 5 of the right slot.
    do_reset();
    fork
      run_slots(6, 32, 5);
      begin
        push_pair(W'($urandom), W'($urandom));
        waited = 0;
        while (!rst_fired && waited < 6000) begin
          tick();
          waited++;
        end
        if (!rst_fired) check_eq("midrst_timeout", 1, 0);
        push_pair(W'($urandom), W'($urandom));
      end
    join
    check_eq("midrst_seen", rst_fired, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
